// File: rtl/branch_resolve_unit_if.sv
// Request/result bus of the branch resolution unit: producer drives in_*, consumer takes out_*.
interface branch_resolve_unit_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        in_kind;
  logic [1:0]        in_cond;
  logic              in_unsigned;
  logic [XLEN-1:0]   in_rs1;
  logic [XLEN-1:0]   in_rs2;
  logic [XLEN-1:0]   in_pc;
  logic [XLEN-1:0]   in_imm;
  logic              in_pred_taken;
  logic [XLEN-1:0]   in_pred_target;
  logic [TAG_W-1:0]  in_tag;

  logic              out_valid;
  logic              out_ready;
  logic [TAG_W-1:0]  out_tag;
  logic              out_taken;
  logic [XLEN-1:0]   out_next_pc;
  logic [XLEN-1:0]   out_link;
  logic              out_mispredict;
  logic              out_misaligned;

  // Environment side: issues requests and consumes results
  modport master (
    output in_valid, in_kind, in_cond, in_unsigned, in_rs1, in_rs2, in_pc, in_imm,
           in_pred_taken, in_pred_target, in_tag, out_ready,
    input  in_ready, out_valid, out_tag, out_taken, out_next_pc, out_link,
           out_mispredict, out_misaligned
  );

  // Unit side
  modport slave (
    input  in_valid, in_kind, in_cond, in_unsigned, in_rs1, in_rs2, in_pc, in_imm,
           in_pred_taken, in_pred_target, in_tag, out_ready,
    output in_ready, out_valid, out_tag, out_taken, out_next_pc, out_link,
           out_mispredict, out_misaligned
  );
endinterface

// File: rtl/branch_resolve_unit.sv
// Single-stage branch/JAL/JALR resolution with misprediction detection and a saturating counter.
module branch_resolve_unit #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 5,
  parameter int unsigned CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  branch_resolve_unit_if.slave bus,
  output logic [CNT_W-1:0]     mispredict_count
);
  localparam logic [1:0] KIND_BRANCH = 2'b00;
  localparam logic [1:0] KIND_JAL    = 2'b01;
  localparam logic [1:0] KIND_JALR   = 2'b10;
  localparam logic [1:0] COND_EQ     = 2'b00;
  localparam logic [1:0] COND_NE     = 2'b01;
  localparam logic [1:0] COND_LT     = 2'b10;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic              valid_q;
  logic [TAG_W-1:0]  tag_q;
  logic              taken_q;
  logic [XLEN-1:0]   next_pc_q;
  logic [XLEN-1:0]   link_q;
  logic              mispredict_q;
  logic              misaligned_q;
  logic [CNT_W-1:0]  count_q;

  logic              accept_c;
  logic              deliver_c;
  logic              eq_c;
  logic              lt_c;
  logic              cond_taken_c;
  logic              taken_c;
  logic [XLEN-1:0]   pc_imm_c;
  logic [XLEN-1:0]   rs1_imm_c;
  logic [XLEN-1:0]   link_c;
  logic [XLEN-1:0]   target_c;
  logic [XLEN-1:0]   next_pc_c;
  logic              mispredict_c;
  logic              misaligned_c;

  // Handshake: a held result frees the slot only when it is being consumed
  assign bus.in_ready = !valid_q || bus.out_ready;
  assign accept_c     = bus.in_valid && bus.in_ready && !flush;
  assign deliver_c    = valid_q && bus.out_ready && !flush;

  assign bus.out_valid      = valid_q;
  assign bus.out_tag        = tag_q;
  assign bus.out_taken      = taken_q;
  assign bus.out_next_pc    = next_pc_q;
  assign bus.out_link       = link_q;
  assign bus.out_mispredict = mispredict_q;
  assign bus.out_misaligned = misaligned_q;
  assign mispredict_count   = count_q;

  // Condition evaluation, target computation and prediction check
  always_comb begin
    eq_c         = (bus.in_rs1 == bus.in_rs2);
    lt_c         = bus.in_unsigned ? (bus.in_rs1 < bus.in_rs2)
                                   : ($signed(bus.in_rs1) < $signed(bus.in_rs2));
    pc_imm_c     = bus.in_pc + bus.in_imm;
    rs1_imm_c    = bus.in_rs1 + bus.in_imm;
    link_c       = bus.in_pc + XLEN'(4);
    cond_taken_c = 1'b0;
    taken_c      = 1'b0;
    target_c     = '0;
    case (bus.in_cond)
      COND_EQ: cond_taken_c = eq_c;
      COND_NE: cond_taken_c = !eq_c;
      COND_LT: cond_taken_c = lt_c;
      default: cond_taken_c = !lt_c;
    endcase
    case (bus.in_kind)
      KIND_BRANCH: begin
        taken_c  = cond_taken_c;
        target_c = pc_imm_c;
      end
      KIND_JAL: begin
        taken_c  = 1'b1;
        target_c = pc_imm_c;
      end
      KIND_JALR: begin
        taken_c  = 1'b1;
        target_c = {rs1_imm_c[XLEN-1:1], 1'b0};
      end
      default: begin
        taken_c  = 1'b0;
        target_c = '0;
      end
    endcase
    next_pc_c    = taken_c ? target_c : link_c;
    mispredict_c = (taken_c != bus.in_pred_taken) ||
                   (taken_c && (target_c != bus.in_pred_target));
    misaligned_c = taken_c && next_pc_c[1];
  end

  // Result register: load on accept, hold under back-pressure, kill on flush
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q      <= 1'b0;
      tag_q        <= '0;
      taken_q      <= 1'b0;
      next_pc_q    <= '0;
      link_q       <= '0;
      mispredict_q <= 1'b0;
      misaligned_q <= 1'b0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (accept_c) begin
      valid_q      <= 1'b1;
      tag_q        <= bus.in_tag;
      taken_q      <= taken_c;
      next_pc_q    <= next_pc_c;
      link_q       <= link_c;
      mispredict_q <= mispredict_c;
      misaligned_q <= misaligned_c;
    end else if (bus.out_ready) begin
      valid_q <= 1'b0;
    end
  end

  // Saturating count of mispredicts actually handed to the consumer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (deliver_c && mispredict_q && (count_q != CNT_MAX)) begin
      count_q <= count_q + CNT_W'(1);
    end
  end
endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Parametrised, single-stage pipelined branch resolution unit for the RV32 execute path.
- Handles conditional branches (EQ/NE/LT/GE, signed/unsigned), JAL and JALR:
  - evaluates the condition;
  - computes the resolved next PC and the link address;
  - compares the result against the front-end prediction and flags mispredictions.
- Valid/ready handshake on both sides, flush input for pipeline kill, saturating mispredict counter for performance monitoring.

Parameters:
- XLEN, 32, operand/PC width in bits (32 or 64).
- TAG_W, 5, width of the instruction tag (ROB index) carried through.
- CNT_W, 16, width of the saturating mispredict counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  kill the in-flight and incoming op this cycle
- in_valid  in  1  request valid
- in_ready  out  1  unit can accept a request
- in_kind  in  2  00 BRANCH, 01 JAL, 10 JALR, 11 reserved
- in_cond  in  2  00 EQ, 01 NE, 10 LT, 11 GE (BRANCH only)
- in_unsigned  in  1  unsigned compare for LT/GE
- in_rs1  in  XLEN  operand 1 (JALR base)
- in_rs2  in  XLEN  operand 2
- in_pc  in  XLEN  instruction PC
- in_imm  in  XLEN  sign-extended offset
- in_pred_taken  in  1  front-end predicted taken
- in_pred_target  in  XLEN  front-end predicted next PC
- in_tag  in  TAG_W  instruction tag
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_tag  out  TAG_W  tag of result
- out_taken  out  1  resolved taken
- out_next_pc  out  XLEN  resolved next PC
- out_link  out  XLEN  pc+4 (rd value for JAL/JALR)
- out_mispredict  out  1  prediction was wrong
- out_misaligned  out  1  taken target has bit[1] set
- mispredict_count  out  CNT_W  saturating count of delivered mispredicts

Behaviour:
- Reset (rst_n low, async): out_valid=0, mispredict_count=0. All other out_* registers reset to 0.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational; independent of flush).
  - Accept when in_valid && in_ready && !flush.
  - Latency is exactly 1 cycle. Throughput is 1/cycle when out_ready is held high.
- Output register hold: while out_valid && !out_ready, all out_* hold stable.
- Compare (BRANCH):
  - eq = rs1==rs2.
  - lt is unsigned or signed ($signed) per in_unsigned, over the full XLEN.
  - taken = EQ:eq, NE:!eq, LT:lt, GE:!lt.
- taken by kind: JAL/JALR → 1. Reserved kind → 0, with out_mispredict = in_pred_taken.
- target:
  - BRANCH/JAL: pc+imm.
  - JALR: (rs1+imm) with bit0 cleared.
  - All adds are modulo 2^XLEN.
- next_pc = taken ? target : pc+4. link = pc+4 (wraps modulo 2^XLEN).
- mispredict = (taken != pred_taken) || (taken && target != pred_target). For not-taken, pred_target is ignored.
- misaligned = taken && next_pc[1]. The result is still delivered; the exception is raised downstream.
- Flush:
  - Next cycle out_valid=0, regardless of out_ready.
  - An input presented the same cycle is dropped.
  - No counter increment for the flushed result.
- Counter: increments on each output handshake (out_valid && out_ready && !flush) with out_mispredict=1. It saturates at 2^CNT_W-1 and does not wrap.
- Reset asserted mid-operation: the in-flight result is discarded immediately, and out_valid drops asynchronously.

Test Plan:
- BEQ, rs1=rs2=0x10, pc=0x100, imm=0x20, pred_taken=1, pred_target=0x120 → next cycle out_valid=1, taken=1, next_pc=0x120, mispredict=0, count=0.
- BLT signed rs1=0xFFFFFFFF, rs2=1 → taken=1. Same with in_unsigned=1 → taken=0, next_pc=pc+4. With pred_taken=1 → mispredict=1, count increments to 1 on handshake.
- JALR rs1=0x1003, imm=0, pc=0x200, pred_target=0x1002 → next_pc=0x1002, link=0x204, mispredict=0, misaligned=1.
- Back-pressure: out_ready=0 for 3 cycles with in_valid=1 → in_ready=0, outputs stable. Raise out_ready → back-to-back results, one per cycle, none lost or duplicated.
- Flush on the cycle after accept, out_ready=0 → out_valid=0 next cycle, count unchanged. An input presented with flush=1 never appears.
- CNT_W=2: 5 delivered mispredicts → count 1,2,3,3,3. Assert rst_n low mid-stream → count=0, out_valid=0 immediately.
